// File: rtl/vn_layer_pkg.sv
// Shared definitions for the layered variable-node update stage.
//   W        : message width on the check-node interface (sign-magnitude)
//   SAT_MAX  : symmetric saturation bound for the internal W+1 bit datapath
//   state_t  : control FSM states
//   sm2tc    : sign-magnitude -> two's complement (W+1 bits), -0 maps to 0
//   tc2sm    : two's complement (already saturated) -> sign-magnitude, 0 -> +0
//   sat17    : clamp a W+1 bit value to +/-SAT_MAX
package vn_layer_pkg;

  localparam int W       = 16;
  localparam int SAT_MAX = 32767;

  localparam logic signed [W:0] SAT_HI = (W+1)'(SAT_MAX);
  localparam logic signed [W:0] SAT_LO = -SAT_HI;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    UPDATE,
    DONE
  } state_t;

  function automatic logic signed [W:0] sm2tc(input logic [W-1:0] x);
    logic signed [W:0] mag;
    mag = {2'b00, x[W-2:0]};
    return x[W-1] ? -mag : mag;
  endfunction

  // Input is expected inside +/-SAT_MAX, so the magnitude fits in W-1 bits.
  function automatic logic [W-1:0] tc2sm(input logic signed [W:0] v);
    logic signed [W:0] mag;
    mag = v[W] ? -v : v;
    return {v[W], mag[W-2:0]};
  endfunction

  function automatic logic signed [W:0] sat17(input logic signed [W:0] v);
    if (v > SAT_HI) begin
      return SAT_HI;
    end else if (v < SAT_LO) begin
      return SAT_LO;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/vn_layer_update_lane.sv
// One lane of the variable-node update: posterior L_v, the extrinsic value
// sent to the check node (lcn_hold), and the stored check message per layer.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture channel LLR (llr), clear all stored messages
//   issue           : register lcn = sm(sat(L_v - rcv_mem[layer]))
//   update          : L_v = sat(lcn_hold + rcv), rcv_mem[layer] = rcv
//   layer           : current layer index
//   llr, rcv        : channel LLR (two's complement) / check message (s-m)
//   lcn             : registered sign-magnitude message to the check node
//   sign            : sign bit of L_v
//   iter_end        : (EARLY_TERM_EN) clear the sign-flip flag
//   flip_any        : (EARLY_TERM_EN) L_v sign changed during this iteration,
//                     including the update happening this cycle
// Optional feature macro: EARLY_TERM_EN
module vn_lane
  import vn_layer_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               issue,
  input  logic               update,
  input  logic [LAYER_W-1:0] layer,
  input  logic [W-1:0]       llr,
  input  logic [W-1:0]       rcv,
  output logic [W-1:0]       lcn,
  output logic               sign
`ifdef EARLY_TERM_EN
  ,
  input  logic               iter_end,
  output logic               flip_any
`endif
);

  logic signed [W:0] lv;
  logic signed [W:0] lcn_hold;
  logic signed [W:0] lcn_t;
  logic signed [W:0] lv_next;
  logic [W-1:0]      rcv_mem [NUM_LAYERS];

  always_comb begin
    lcn_t   = sat17(lv - sm2tc(rcv_mem[layer]));
    lv_next = sat17(lcn_hold + sm2tc(rcv));
  end

  assign sign = lv[W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lv       <= '0;
      lcn_hold <= '0;
      lcn      <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) rcv_mem[i] <= '0;
    end else begin
      if (load) begin
        // Sign-extend then clamp: -32768 becomes -32767.
        lv <= sat17({llr[W-1], llr});
        for (int i = 0; i < NUM_LAYERS; i++) rcv_mem[i] <= '0;
      end
      if (issue) begin
        lcn      <= tc2sm(lcn_t);
        lcn_hold <= lcn_t;
      end
      if (update) begin
        lv             <= lv_next;
        rcv_mem[layer] <= rcv;
      end
    end
  end

`ifdef EARLY_TERM_EN
  logic flip_flag;
  logic flip_now;

  assign flip_now = update & (lv_next[W] ^ lv[W]);
  assign flip_any = flip_flag | flip_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_flag <= 1'b0;
    end else if (load || iter_end) begin
      flip_flag <= 1'b0;
    end else if (flip_now) begin
      flip_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/vn_layer_update.sv
// Layered variable-node update stage around a check-node unit.
// Per layer: ISSUE drives lcn_out = sm(L_v - Rcv_old), WAIT covers the
// check-node latency, UPDATE absorbs rcv_in: L_v = Lcn + Rcv_new.
// After MAX_ITER iterations the sign bits of L_v are offered as decisions.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   llr_valid/ready/llr_in : channel LLR block input (ready only in IDLE)
//   lcn_out       : registered sign-magnitude messages to the check node
//   rcv_in        : sign-magnitude check messages, sampled on the edge that
//                   ends UPDATE (CNU_LAT+1 edges after lcn_out changed)
//   hard_valid/ready/hard_out : decision output (bit k = 1 when L_v[k] < 0)
//   iter_count    : completed iterations
//   busy          : high outside IDLE
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and data stable until that edge.
// Optional feature macro: EARLY_TERM_EN (stop once an iteration >= 2 ends
// without any L_v sign change).
module vn_layer_update
  import vn_layer_pkg::*;
#(
  parameter int LANES      = 32,
  parameter int NUM_LAYERS = 4,
  parameter int MAX_ITER   = 8,
  parameter int CNU_LAT    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               llr_valid,
  output logic               llr_ready,
  input  logic [LANES*W-1:0] llr_in,
  output logic [LANES*W-1:0] lcn_out,
  input  logic [LANES*W-1:0] rcv_in,
  output logic               hard_valid,
  input  logic               hard_ready,
  output logic [LANES-1:0]   hard_out,
  output logic [3:0]         iter_count,
  output logic               busy
);

  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W   = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1;

  state_t             state;
  state_t             state_next;
  logic [LAYER_W-1:0] layer;
  logic [CNT_W-1:0]   wait_cnt;
  logic               load;
  logic               issue;
  logic               update;
  logic               last_layer;
  logic [3:0]         iter_inc;
  logic               stop;
  logic [LANES-1:0]   sign_bits;

`ifdef EARLY_TERM_EN
  logic             iter_end;
  logic [LANES-1:0] flip_bits;
  assign iter_end = update & last_layer;
`endif

  assign load = llr_valid & llr_ready;

  always_comb begin
    last_layer = (layer == LAYER_W'(NUM_LAYERS - 1));
    iter_inc   = iter_count + 4'd1;
    stop       = last_layer && (iter_inc == 4'(MAX_ITER));
`ifdef EARLY_TERM_EN
    if (last_layer && (iter_inc >= 4'd2) && !(|flip_bits)) stop = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_cnt == '0) state_next = UPDATE;
      UPDATE:  state_next = stop ? DONE : ISSUE;
      DONE:    if (hard_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    llr_ready  = 1'b0;
    busy       = 1'b1;
    hard_valid = 1'b0;
    issue      = 1'b0;
    update     = 1'b0;
    case (state)
      IDLE: begin
        llr_ready = 1'b1;
        busy      = 1'b0;
      end
      ISSUE:   issue      = 1'b1;
      UPDATE:  update     = 1'b1;
      DONE:    hard_valid = 1'b1;
      default: ;
    endcase
  end

  // Layer / iteration / latency counters. WAIT lasts CNU_LAT cycles: the
  // counter is loaded with CNU_LAT-1 in ISSUE and WAIT exits at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer      <= '0;
      iter_count <= '0;
      wait_cnt   <= '0;
    end else begin
      if (load) begin
        layer      <= '0;
        iter_count <= '0;
      end else if (update) begin
        if (last_layer) begin
          layer      <= '0;
          iter_count <= iter_inc;
        end else begin
          layer <= layer + 1'b1;
        end
      end
      if (issue) begin
        wait_cnt <= CNT_W'(CNU_LAT - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  assign hard_out = hard_valid ? sign_bits : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vn_lane #(
      .NUM_LAYERS (NUM_LAYERS),
      .LAYER_W    (LAYER_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .issue    (issue),
      .update   (update),
      .layer    (layer),
      .llr      (llr_in[k*W +: W]),
      .rcv      (rcv_in[k*W +: W]),
      .lcn      (lcn_out[k*W +: W]),
      .sign     (sign_bits[k])
`ifdef EARLY_TERM_EN
      ,
      .iter_end (iter_end),
      .flip_any (flip_bits[k])
`endif
    );
  end

endmodule

// File: tb/tb_vn_layer_update.sv
// Bench for vn_layer_update: table of uniform-lane stimulus records with
// spot values, a per-lane integer reference model feeding an expected queue
// of lcn_out words, and a check-node model that presents the programmed
// rcv_in only in the cycle before the sampling edge (random data otherwise).
module tb_vn_layer_update;

  localparam int LANES      = 32;
  localparam int W          = 16;
  localparam int NUM_LAYERS = 4;
  localparam int MAX_ITER   = 8;
  localparam int CNU_LAT    = 5;
  localparam int LAYER_CYC  = CNU_LAT + 2;
  localparam int NVEC       = 6;
`ifdef EARLY_TERM_EN
  localparam int EXP_ITER = 2;
`else
  localparam int EXP_ITER = 8;
`endif

  logic               clk;
  logic               rst;
  logic               llr_valid;
  logic               llr_ready;
  logic [LANES*W-1:0] llr_in;
  logic [LANES*W-1:0] lcn_out;
  logic [LANES*W-1:0] rcv_in;
  logic               hard_valid;
  logic               hard_ready;
  logic [LANES-1:0]   hard_out;
  logic [3:0]         iter_count;
  logic               busy;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vn_layer_update #(
    .LANES      (LANES),
    .NUM_LAYERS (NUM_LAYERS),
    .MAX_ITER   (MAX_ITER),
    .CNU_LAT    (CNU_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .llr_valid  (llr_valid),
    .llr_ready  (llr_ready),
    .llr_in     (llr_in),
    .lcn_out    (lcn_out),
    .rcv_in     (rcv_in),
    .hard_valid (hard_valid),
    .hard_ready (hard_ready),
    .hard_out   (hard_out),
    .iter_count (iter_count),
    .busy       (busy)
  );

  typedef struct {
    logic [W-1:0]     llr;
    logic [W-1:0]     rcv;
    logic [W-1:0]     llr3;
    logic [W-1:0]     rcv3;
    logic [W-1:0]     e0_l0;
    logic [W-1:0]     e0_l3;
    logic [W-1:0]     e1_l0;
    logic [W-1:0]     e1_l3;
    logic [W-1:0]     e4_l0;
    logic [W-1:0]     e4_l3;
    logic [LANES-1:0] hard;
  } vec_t;

  vec_t               tbl [NVEC];
  vec_t               cur;
  int                 total;
  int                 bad;
  int                 cyc;
  logic [LANES*W-1:0] exp_q [$];
  logic [W-1:0]       rcv_prog [LANES];
  int                 m_l [LANES];
  int                 m_hold [LANES];
  int                 m_r [LANES][NUM_LAYERS];
  bit                 m_flip [LANES];
  int                 m_iter;
  int                 m_layer;
  bit                 m_done;

  // Reference arithmetic in plain integers
  function automatic int sm_int(input logic [W-1:0] x);
    int m;
    m = int'(x[W-2:0]);
    return x[W-1] ? -m : m;
  endfunction

  function automatic int clampi(input int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  function automatic logic [W-1:0] int_sm(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return {(v < 0), a[W-2:0]};
  endfunction

  task automatic check(input string name, input logic [LANES*W-1:0] act,
                       input logic [LANES*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Check-node model / scoreboard step, called once per cycle after the edge
  task automatic step();
    int ph;
    int nl;
    bit any_flip;
    logic [LANES*W-1:0] e;
    ph = cyc % LAYER_CYC;
    for (int k = 0; k < LANES; k++)
      rcv_in[k*W +: W] = (ph == LAYER_CYC - 1) ? rcv_prog[k] : W'($urandom);
    if (m_done) return;
    if (ph == 0) begin
      e = '0;
      for (int k = 0; k < LANES; k++) begin
        m_hold[k] = clampi(m_l[k] - m_r[k][m_layer]);
        e[k*W +: W] = int_sm(m_hold[k]);
      end
      exp_q.push_back(e);
    end else if (ph == 1) begin
      if (exp_q.size() == 0) begin
        check("lcn_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("lcn_out", lcn_out, e);
      end
    end else if (ph == LAYER_CYC - 1) begin
      for (int k = 0; k < LANES; k++) begin
        nl = clampi(m_hold[k] + sm_int(rcv_prog[k]));
        if ((nl < 0) != (m_l[k] < 0)) m_flip[k] = 1'b1;
        m_l[k] = nl;
        m_r[k][m_layer] = sm_int(rcv_prog[k]);
      end
      if (m_layer == NUM_LAYERS - 1) begin
        m_layer = 0;
        m_iter++;
        any_flip = 1'b0;
        for (int k = 0; k < LANES; k++) begin
          any_flip |= m_flip[k];
          m_flip[k] = 1'b0;
        end
        if (m_iter == MAX_ITER) m_done = 1'b1;
`ifdef EARLY_TERM_EN
        if (m_iter >= 2 && !any_flip) m_done = 1'b1;
`endif
        if (m_done) check("hard_valid_before_done", hard_valid, 0);
      end else begin
        m_layer++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    step();
  endtask

  // Driver: program lanes, reset the model, offer the block for one edge
  task automatic start_vec(input int idx);
    cur = tbl[idx];
    exp_q.delete();
    m_done  = 1'b0;
    m_iter  = 0;
    m_layer = 0;
    for (int k = 0; k < LANES; k++) begin
      llr_in[k*W +: W] = (k == 3) ? cur.llr3 : cur.llr;
      rcv_prog[k]      = (k == 3) ? cur.rcv3 : cur.rcv;
      m_l[k]    = clampi(int'($signed(llr_in[k*W +: W])));
      m_flip[k] = 1'b0;
      for (int j = 0; j < NUM_LAYERS; j++) m_r[k][j] = 0;
    end
    @(negedge clk);
    check("llr_ready_idle", llr_ready, 1);
    llr_valid = 1'b1;
    @(posedge clk);
    #1;
    llr_valid = 1'b0;
    cyc = 0;
    step();
  endtask

  task automatic run_vec(input int idx);
    int guard;
    int j;
    logic [LANES-1:0] hm;
    start_vec(idx);
    guard = 0;
    while (!(m_done && (cyc % LAYER_CYC == 0)) && guard < 400) begin
      tick();
      guard++;
      if (cyc % LAYER_CYC == 1) begin
        j = cyc / LAYER_CYC;
        if (j == 0) begin
          check("lcn_l0_lane0", lcn_out[0 +: W], cur.e0_l0);
          check("lcn_l0_lane3", lcn_out[3*W +: W], cur.e0_l3);
        end else if (j == 1) begin
          check("lcn_l1_lane0", lcn_out[0 +: W], cur.e1_l0);
          check("lcn_l1_lane3", lcn_out[3*W +: W], cur.e1_l3);
        end else if (j == 4) begin
          check("lcn_it2_lane0", lcn_out[0 +: W], cur.e4_l0);
          check("lcn_it2_lane3", lcn_out[3*W +: W], cur.e4_l3);
        end
      end
      if (idx == 0 && cyc == 10) begin
        check("llr_ready_busy", llr_ready, 0);
        for (int k = 0; k < LANES; k++) llr_in[k*W +: W] = W'($urandom);
        llr_valid = 1'b1;
      end
      if (idx == 0 && cyc == 11) llr_valid = 1'b0;
    end
    if (guard >= 400) check("run_timeout", 1, 0);
    check("hard_valid_done", hard_valid, 1);
    check("iter_count", iter_count, EXP_ITER);
    check("hard_out_tbl", hard_out, cur.hard);
    for (int k = 0; k < LANES; k++) hm[k] = (m_l[k] < 0);
    check("hard_out_model", hard_out, hm);
    if (idx == 0) begin
      for (int n = 0; n < 20; n++) begin
        tick();
        check("hold_hard_valid", hard_valid, 1);
        check("hold_hard_out", hard_out, cur.hard);
      end
    end
    hard_ready = 1'b1;
    tick();
    hard_ready = 1'b0;
    check("idle_after_accept", {llr_ready, hard_valid, busy}, 3'b100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    m_done     = 1'b1;
    rst        = 1'b1;
    llr_valid  = 1'b0;
    hard_ready = 1'b0;
    llr_in     = '0;
    rcv_in     = '0;

    //              llr       rcv       llr3      rcv3      l0 lane0  l0 lane3  l1 lane0  l1 lane3  it2 l0    it2 l3    hard
    tbl[0] = '{16'h0064, 16'h0005, 16'h0064, 16'h0005, 16'h0064, 16'h0064, 16'h0069, 16'h0069, 16'h0073, 16'h0073, 32'h0};
    tbl[1] = '{16'h0064, 16'h0005, 16'hFFCE, 16'h8014, 16'h0064, 16'h8032, 16'h0069, 16'h8046, 16'h0073, 16'h806E, 32'h8};
    tbl[2] = '{16'h7D00, 16'h03E8, 16'h7D00, 16'h03E8, 16'h7D00, 16'h7D00, 16'h7FFF, 16'h7FFF, 16'h7C17, 16'h7C17, 32'h0};
    tbl[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF};
    tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'h0};
    tbl[5] = '{16'hFFFB, 16'h0005, 16'hFFFB, 16'h0005, 16'h8005, 16'h8005, 16'h0000, 16'h0000, 16'h000A, 16'h000A, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_llr_ready", llr_ready, 1);
    check("rst_lcn_out", lcn_out, 0);
    check("rst_outputs", {hard_valid, busy, iter_count, hard_out}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset during WAIT aborts to IDLE
    start_vec(0);
    repeat (3) tick();
    check("wait_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_idle", {llr_ready, busy, hard_valid}, 3'b100);
    check("abort_lcn_out", lcn_out, 0);
    check("abort_iter", iter_count, 0);
    @(negedge clk);
    rst = 1'b0;
    m_done = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
